// File: rtl/text_console_writer.sv
// Terminal-style writer that turns a {char, attr} byte stream into cell writes on the
// text RAM write port, keeping a cursor inside a window so the border art is untouched.
module text_console_writer #(
  parameter int          WIN_COL0 = 1,
  parameter int          WIN_ROW0 = 1,
  parameter int          WIN_COLS = 28,
  parameter int          WIN_ROWS = 15,
  parameter logic [7:0]  CLR_ATTR = 8'h07
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        ram_ce,
  output logic [9:0]  ram_ada,
  output logic [15:0] ram_din,
  output logic [4:0]  cur_col,
  output logic [3:0]  cur_row,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_ALL} state_t;

  localparam logic [4:0]  LAST_COL = 5'(WIN_COLS - 1);
  localparam logic [3:0]  LAST_ROW = 4'(WIN_ROWS - 1);
  localparam logic [4:0]  COL0     = 5'(WIN_COL0);
  localparam logic [4:0]  ROW0     = 5'(WIN_ROW0);
  localparam logic [15:0] BLANK    = {CLR_ATTR, 8'h20};

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_col, w_col_nxt;
  logic [3:0]  r_row, w_row_nxt;
  logic [4:0]  r_ccol, w_ccol_nxt;
  logic [3:0]  r_crow, w_crow_nxt;
  logic        r_ce, w_we;
  logic [9:0]  r_ada, w_ada;
  logic [15:0] r_din, w_din;
  logic        w_accept;

  function automatic logic [9:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
    logic [4:0] abs_row;
    logic [4:0] abs_col;
    abs_row = ROW0 + {1'b0, row};
    abs_col = COL0 + col;
    return {abs_row, abs_col};
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] row);
    return (row == LAST_ROW) ? 4'd0 : row + 4'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= CLR_ALL;
    else         r_state <= w_state_nxt;
  end

  // The write port is registered: a write decided in cycle N is presented in cycle N+1.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_ccol_nxt  = r_ccol;
    w_crow_nxt  = r_crow;
    w_we        = 1'b0;
    w_ada       = r_ada;
    w_din       = r_din;
    in_ready    = (r_state == IDLE);
    w_accept    = in_valid & in_ready;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_char >= 8'h20) begin
            w_we        = 1'b1;
            w_ada       = cell_addr(r_row, r_col);
            w_din       = {in_attr, in_char};
            w_state_nxt = PUT;
          end else begin
            case (in_char)
              8'h0D: w_col_nxt = 5'd0;
              8'h0A: begin
                w_row_nxt   = next_row(r_row);
                w_state_nxt = CLR_LINE;
              end
              8'h08: if (r_col != 5'd0) w_col_nxt = r_col - 5'd1;
              8'h0C: begin
                w_col_nxt   = 5'd0;
                w_row_nxt   = 4'd0;
                w_state_nxt = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        if (r_col == LAST_COL) begin
          w_col_nxt   = 5'd0;
          w_row_nxt   = next_row(r_row);
          w_state_nxt = CLR_LINE;
        end else begin
          w_col_nxt   = r_col + 5'd1;
          w_state_nxt = IDLE;
        end
      end
      CLR_LINE: begin
        w_we  = 1'b1;
        w_ada = cell_addr(r_row, r_ccol);
        w_din = BLANK;
        if (r_ccol == LAST_COL) begin
          w_ccol_nxt  = 5'd0;
          w_state_nxt = IDLE;
        end else begin
          w_ccol_nxt = r_ccol + 5'd1;
        end
      end
      CLR_ALL: begin
        w_we  = 1'b1;
        w_ada = cell_addr(r_crow, r_ccol);
        w_din = BLANK;
        if (r_ccol == LAST_COL) begin
          w_ccol_nxt = 5'd0;
          if (r_crow == LAST_ROW) begin
            w_crow_nxt  = 4'd0;
            w_state_nxt = IDLE;
          end else begin
            w_crow_nxt = r_crow + 4'd1;
          end
        end else begin
          w_ccol_nxt = r_ccol + 5'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col  <= 5'd0;
      r_row  <= 4'd0;
      r_ccol <= 5'd0;
      r_crow <= 4'd0;
      r_ce   <= 1'b0;
      r_ada  <= 10'd0;
      r_din  <= 16'd0;
    end else begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_ccol <= w_ccol_nxt;
      r_crow <= w_crow_nxt;
      r_ce   <= w_we;
      r_ada  <= w_ada;
      r_din  <= w_din;
    end
  end

  assign ram_ce  = r_ce;
  assign ram_ada = r_ada;
  assign ram_din = r_din;
  assign cur_col = r_col;
  assign cur_row = r_row;
  assign busy    = (r_state == CLR_LINE) || (r_state == CLR_ALL);

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed sequences, a vector table and random bytes
// checked against a cursor/cell-list model of the console.
module tb_text_console_writer;

  localparam int C0 = 1;
  localparam int R0 = 1;
  localparam int NC = 28;
  localparam int NR = 15;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_ready;
  logic        ram_ce;
  logic [9:0]  ram_ada;
  logic [15:0] ram_din;
  logic [4:0]  cur_col;
  logic [3:0]  cur_row;
  logic        busy;

  text_console_writer #(
    .WIN_COL0(C0), .WIN_ROW0(R0), .WIN_COLS(NC), .WIN_ROWS(NR), .CLR_ATTR(8'h07)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr), .ram_ce(ram_ce), .ram_ada(ram_ada),
    .ram_din(ram_din), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  int mcol = 0;
  int mrow = 0;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] at;
    int         col;
    int         row;
    int         nw;
  } vec_t;
  vec_t tbl[9];

  function automatic bit in_window(input logic [9:0] a);
    int r;
    int c;
    r = int'(a[9:5]);
    c = int'(a[4:0]);
    return (r >= R0) && (r < R0 + NR) && (c >= C0) && (c < C0 + NC);
  endfunction

  always @(negedge clk) begin
    if (resetn && ram_ce) begin
      got_q.push_back({ram_ada, ram_din});
      n_tests++;
      if (!in_window(ram_ada)) begin
        n_fail++;
        $display("FAIL window: write at ada=%0d lies outside the window", ram_ada);
      end
    end
  end

  function automatic logic [9:0] addr_of(input int r, input int c);
    return 10'((R0 + r) * 32 + C0 + c);
  endfunction

  task automatic push_line(input int r);
    for (int c = 0; c < NC; c++) exp_q.push_back({addr_of(r, c), 16'h0720});
  endtask

  task automatic push_all();
    for (int r = 0; r < NR; r++) push_line(r);
  endtask

  task automatic model_byte(input logic [7:0] ch, input logic [7:0] at);
    if (ch >= 8'h20) begin
      exp_q.push_back({addr_of(mrow, mcol), at, ch});
      mcol++;
      if (mcol == NC) begin
        mcol = 0;
        mrow = (mrow + 1) % NR;
        push_line(mrow);
      end
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h0A) begin
      mrow = (mrow + 1) % NR;
      push_line(mrow);
    end else if (ch == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (ch == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      push_all();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    int bad;
    bad = -1;
    n_tests++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++;
      if (bad >= 0)
        $display("FAIL %s: write %0d got ada=%0d din=%h, expected ada=%0d din=%h", name, bad,
                 got_q[bad][25:16], got_q[bad][15:0], exp_q[bad][25:16], exp_q[bad][15:0]);
      else
        $display("FAIL %s: got %0d writes, expected %0d", name, got_q.size(), exp_q.size());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] ch, input logic [7:0] at);
    int k;
    k = 0;
    @(negedge clk);
    in_char  = ch;
    in_attr  = at;
    in_valid = 1'b1;
    while (!in_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0d after %0d cycles, expected 1", in_ready, k);
    end else begin
      @(posedge clk);
      #1;
      model_byte(ch, at);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: in_ready=%0d, expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"},    32'(ram_ce),   32'd0);
    check({tag, "_ada"},   32'(ram_ada),  32'd0);
    check({tag, "_din"},   32'(ram_din),  32'd0);
    check({tag, "_col"},   32'(cur_col),  32'd0);
    check({tag, "_row"},   32'(cur_row),  32'd0);
    check({tag, "_busy"},  32'(busy),     32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Releases reset at a falling edge and follows the automatic window clear to its end.
  task automatic release_and_clear(input string tag);
    int nb;
    int k;
    nb = 0;
    k  = 0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check({tag, "_ready_first"}, 32'(in_ready), 32'd0);
    while (!in_ready && k < 1000) begin
      if (busy) nb++;
      @(negedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd420);
    check({tag, "_ready_end"}, 32'(in_ready), 32'd1);
    mcol = 0;
    mrow = 0;
    push_all();
    check_writes({tag, "_writes"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h41, 8'h1F, 1, 0, 1};
    tbl[1] = '{8'h42, 8'h2E, 2, 0, 1};
    tbl[2] = '{8'h0D, 8'h00, 0, 0, 0};
    tbl[3] = '{8'h08, 8'h00, 0, 0, 0};
    tbl[4] = '{8'h0A, 8'h00, 0, 1, 28};
    tbl[5] = '{8'h43, 8'h07, 1, 1, 1};
    tbl[6] = '{8'h08, 8'h00, 0, 1, 0};
    tbl[7] = '{8'h1B, 8'h55, 0, 1, 0};
    tbl[8] = '{8'h44, 8'h70, 1, 1, 1};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    release_and_clear("init");

    // Single printable character: write one cycle after accept, ready two cycles after.
    @(negedge clk);
    in_char  = 8'h41;
    in_attr  = 8'h1F;
    in_valid = 1'b1;
    check("put_ready_before", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_byte(8'h41, 8'h1F);
    check("put_ce", 32'(ram_ce), 32'd1);
    check("put_ada", 32'(ram_ada), 32'd33);
    check("put_din", 32'(ram_din), 32'h1F41);
    check("put_ready_n1", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("put_ready_n2", 32'(in_ready), 32'd1);
    check("put_col", 32'(cur_col), 32'd1);
    check("put_ce_off", 32'(ram_ce), 32'd0);
    @(negedge clk);
    check_writes("put_writes");

    // A full line of characters wraps onto a freshly cleared row 1.
    send_byte(8'h0D, 8'h00);
    wait_idle();
    for (int i = 0; i < NC; i++) begin
      send_byte(8'($urandom_range(32, 255)), 8'($urandom_range(0, 255)));
      wait_idle();
    end
    check("wrap_col", 32'(cur_col), 32'd0);
    check("wrap_row", 32'(cur_row), 32'd1);
    check("wrap_nwrites", 32'(got_q.size()), 32'd56);
    if (got_q.size() > 28) check("wrap_first_clear", 32'(got_q[28][25:16]), 32'd65);
    check_writes("wrap_writes");

    send_byte(8'h0C, 8'h00);
    wait_idle();
    check_writes("ff_before_table");
    for (int i = 0; i < 9; i++) begin
      send_byte(tbl[i].ch, tbl[i].at);
      wait_idle();
      check($sformatf("tbl%0d_col", i), 32'(cur_col), 32'(tbl[i].col));
      check($sformatf("tbl%0d_row", i), 32'(cur_row), 32'(tbl[i].row));
      check($sformatf("tbl%0d_nw", i), 32'(got_q.size()), 32'(tbl[i].nw));
      check_writes($sformatf("tbl%0d_writes", i));
    end

    // Row wrap from the last window row back to row 0, then a form feed.
    send_byte(8'h0C, 8'h00);
    wait_idle();
    for (int i = 0; i < NR - 1; i++) begin
      send_byte(8'h0A, 8'h00);
      wait_idle();
    end
    check("lf_row14", 32'(cur_row), 32'd14);
    check_writes("lf_walk_writes");
    send_byte(8'h0A, 8'h00);
    wait_idle();
    check("lf_wrap_row", 32'(cur_row), 32'd0);
    check("lf_wrap_nw", 32'(got_q.size()), 32'd28);
    if (got_q.size() == 28) begin
      check("lf_wrap_first", 32'(got_q[0][25:16]), 32'd33);
      check("lf_wrap_last", 32'(got_q[27][25:16]), 32'd60);
    end
    check_writes("lf_wrap_writes");
    send_byte(8'h58, 8'h0E);
    send_byte(8'h0C, 8'h00);
    wait_idle();
    check("ff_col", 32'(cur_col), 32'd0);
    check("ff_row", 32'(cur_row), 32'd0);
    check_writes("ff_writes");

    // Reset pulled in the middle of a clear; the clear restarts from the origin.
    send_byte(8'h51, 8'h07);
    send_byte(8'h0C, 8'h00);
    repeat (200) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    got_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    release_and_clear("rerun");

    // Random byte stream against the model.
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [7:0] ch;
      r = int'($urandom_range(0, 99));
      if (r < 70)      ch = 8'($urandom_range(32, 255));
      else if (r < 78) ch = 8'h0D;
      else if (r < 86) ch = 8'h0A;
      else if (r < 94) ch = 8'h08;
      else if (r < 96) ch = 8'h0C;
      else             ch = 8'($urandom_range(0, 31));
      send_byte(ch, 8'($urandom_range(0, 255)));
      wait_idle();
      check($sformatf("rnd%0d_col", i), 32'(cur_col), 32'(mcol));
      check($sformatf("rnd%0d_row", i), 32'(cur_row), 32'(mrow));
      check_writes($sformatf("rnd%0d_writes", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Terminal-style writer for the dual-port text RAM that the VGA text renderer reads.
- Accepts a byte stream (character + attribute) on a valid/ready interface and drives the RAM's 16-bit write port. Each cell is written as {attr, char} at word address row*32+col.
- Keeps a cursor inside a configurable window, so the fixed border art in the RAM is never overwritten.
- Handles CR, LF, BS and FF (clear window); fills each new line with blank cells when the cursor moves onto it.

Parameters:
- WIN_COL0, 1, first window column (absolute cell column)
- WIN_ROW0, 1, first window row (absolute cell row)
- WIN_COLS, 28, window width in cells (WIN_COL0+WIN_COLS <= 32)
- WIN_ROWS, 15, window height in rows (absolute row index < 32)
- CLR_ATTR, 8'h07, attribute byte used for blank cells (blank char = 8'h20)

Ports:
- clk  in  1  system clock; also drives the RAM write-port clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  writer can accept a byte this cycle
- in_char  in  8  character code or control code
- in_attr  in  8  attribute for printable characters
- ram_ce  out  1  write enable for the text RAM write port, one cell per cycle
- ram_ada  out  10  word address, {row[4:0], col[4:0]} in absolute cells
- ram_din  out  16  cell data {attr, char}
- cur_col  out  5  cursor column, relative to the window (0..WIN_COLS-1)
- cur_row  out  4  cursor row, relative to the window (0..WIN_ROWS-1)
- busy  out  1  a clear operation is in progress

Behaviour:
- Reset values:
  - in_ready=0 in the first cycle after reset release, because the writer enters CLR_ALL.
  - ram_ce=0, ram_ada=0, ram_din=0, cur_col=0, cur_row=0, busy=1.
  - The window is cleared automatically after reset.
- A byte is accepted when in_valid & in_ready. in_ready=1 only in IDLE.
- States: IDLE, PUT, CLR_LINE, CLR_ALL.
- IDLE, printable byte (>=8'h20): latch the cell and go to PUT.
- PUT (1 cycle):
  - ram_ce=1, ram_ada=(WIN_ROW0+row)*32+(WIN_COL0+col), ram_din={attr,char}.
  - Then col+1. If col was WIN_COLS-1: col=0, row+1 (wraps WIN_ROWS-1 -> 0), go to CLR_LINE. Otherwise go to IDLE.
  - Latency: accept at cycle N, write at N+1, in_ready=1 again at N+2 (no wrap).
- IDLE, 8'h0D (CR): col=0. Stay in IDLE, no RAM write, ready again the next cycle.
- IDLE, 8'h0A (LF): row+1 with wrap, col unchanged, go to CLR_LINE.
- IDLE, 8'h08 (BS): if col>0, col-1; at col 0 nothing happens. No RAM write.
- IDLE, 8'h0C (FF): col=0, row=0, go to CLR_ALL.
- IDLE, any other byte <8'h20: consumed and ignored.
- CLR_LINE:
  - Writes {CLR_ATTR,8'h20} to the WIN_COLS cells of the cursor row, left to right, one per cycle, ram_ce=1 each cycle.
  - Takes exactly WIN_COLS cycles with busy=1, then returns to IDLE.
  - Cursor is not moved.
- CLR_ALL:
  - Writes blanks to all WIN_COLS*WIN_ROWS cells, row-major from window origin.
  - Takes exactly WIN_COLS*WIN_ROWS cycles with busy=1, then IDLE with cursor at 0,0.
- Outside PUT/CLR_*: ram_ce=0, and ram_ada/ram_din hold their last values.
- Writes never fall outside the window: no address with absolute column < WIN_COL0 or >= WIN_COL0+WIN_COLS, or row outside the window.
- in_valid is ignored whenever in_ready=0. The source must hold in_char/in_attr stable while in_valid=1 and not ready.
- Asserting resetn mid-clear:
  - All state returns to its reset values immediately.
  - A full CLR_ALL restarts after release.
  - A partially written line is not resumed.
- cur_col/cur_row are registered and update in the cycle after the event: PUT exit, or the accept cycle for CR/LF/BS/FF.

Test Plan:
1. Reset release -> busy=1 for 420 cycles; ram_ce pulses 420 times covering exactly addresses 33..60, 65..92, ..., 481..508, all with din=16'h0720; then in_ready=1.
2. Send 'A' (8'h41) with attr 8'h1F at cursor 0,0 -> one write, ada=33, din=16'h1F41; cur_col=1; in_ready high again 2 cycles after accept.
3. Send 28 printable chars -> 28 writes at ada 33..60. The 28th write is followed by CLR_LINE on row 1 (ada 65..92, din 16'h0720). Cursor ends at col 0, row 1.
4. Send "AB", CR, BS, LF -> CR gives col 0; BS at col 0 gives no change; LF gives row 1 and clears ada 65..92. No other writes occur.
5. Cursor on row 14, send LF -> row wraps to 0, row 0 cleared (ada 33..60). Send FF -> 420-cycle clear, cursor 0,0.
6. Pull resetn low midway through CLR_ALL (cycle 200) -> outputs immediately at reset values; after release, the full 420-write clear repeats from ada 33.
